// File: rtl/pattern_detect_param_if.sv
// Bundles the data, configuration and status signals of the serial pattern
// detector. The master side drives the stream and configuration, and the
// slave side (the detector) returns the match pulse, match count and error flag.
interface pattern_detect_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               en;
    logic               x;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               y;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output en, x, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  y, match_cnt, cfg_err
    );

    modport slave (
        input  en, x, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output y, match_cnt, cfg_err
    );
endinterface

// File: rtl/pattern_detect_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern of 2..MAX_LEN
// bits. It supports overlapping and non-overlapping match modes, produces a
// registered match pulse, and keeps a saturating match counter.
module pattern_detect_param #(
    parameter int          MAX_LEN     = 8,
    parameter int          CNT_W       = 8,
    parameter logic [15:0] DEF_PATTERN = 16'b0000_0000_0000_0110,
    parameter int          DEF_LEN     = 3
) (
    input  logic clk,
    input  logic rst_n,
    pattern_detect_param_if.slave bus
);
    localparam int                 LEN_W       = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0]   MAX_FILL    = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   MIN_LEN     = LEN_W'(2);
    localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(DEF_LEN);
    localparam logic [MAX_LEN-1:0] RST_PATTERN = DEF_PATTERN[MAX_LEN-1:0];
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               y_q;
    logic               cfg_err_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [MAX_LEN-1:0] history_next;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] len_mask;
    logic               cfg_legal;
    logic               sample;
    logic               hit;

    // Compare the history as it will be after this edge, so a match is
    // flagged on the same edge that samples the completing bit.
    always_comb begin
        history_next = {history[MAX_LEN-2:0], bus.x};
        fill_inc     = (fill == MAX_FILL) ? fill : fill + LEN_W'(1);
        len_mask     = ~({MAX_LEN{1'b1}} << len);
        cfg_legal    = (bus.cfg_len >= MIN_LEN) && (bus.cfg_len <= MAX_FILL);
        sample       = bus.en && !bus.cfg_we;
        hit          = sample && (fill_inc >= len)
                       && ((history_next & len_mask) == (pattern & len_mask));
    end

    // Update configuration, history and fill. A configuration strobe wins
    // over the data stream, and an illegal configuration only drops the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history <= '0;
            fill    <= '0;
            pattern <= RST_PATTERN;
            len     <= RST_LEN;
            overlap <= 1'b1;
        end else if (bus.cfg_we) begin
            if (cfg_legal) begin
                pattern <= bus.cfg_pattern;
                len     <= bus.cfg_len;
                overlap <= bus.cfg_overlap;
                history <= '0;
                fill    <= '0;
            end
        end else if (bus.en) begin
            history <= history_next;
            fill    <= (hit && !overlap) ? '0 : fill_inc;
        end
    end

    // Register the match pulse and the rejected-configuration pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q       <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            y_q       <= hit;
            cfg_err_q <= bus.cfg_we && !cfg_legal;
        end
    end

    // Count matches and saturate at full scale. A clear on the same edge as
    // a match wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.y         = y_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.match_cnt = cnt_q;
endmodule
